// File: rtl/seed_ctrl_pkg.sv
// Shared types and sizing for the SEED round-sequencing controller.
package seed_ctrl_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned BLK_W           = WORD_W * WORDS_PER_BLOCK;
    localparam int unsigned HALF_W          = BLK_W / 2;
    localparam int unsigned WCNT_W          = 2;
    localparam int unsigned MAX_ROUNDS      = 16;
    localparam int unsigned RIDX_W          = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ROUND   = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } state_t;

    // Word idx of a block, word 0 being the most significant.
    function automatic logic [WORD_W-1:0] word_at(input logic [BLK_W-1:0]  blk,
                                                  input logic [WCNT_W-1:0] idx);
        logic [WORD_W-1:0] w;
        unique case (idx)
            2'd0:    w = blk[BLK_W-1            -: WORD_W];
            2'd1:    w = blk[BLK_W-1-WORD_W     -: WORD_W];
            2'd2:    w = blk[BLK_W-1-2*WORD_W   -: WORD_W];
            default: w = blk[WORD_W-1:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/seed_word_buf.sv
// 128-bit block buffer: 32-bit serial shift-in for loading, parallel capture,
// and a 32-bit indexed read port for streaming the result out.
module seed_word_buf
    import seed_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [WORD_W-1:0] shift_word,
    input  logic              cap_en,
    input  logic [BLK_W-1:0]  cap_data,
    input  logic [WCNT_W-1:0] rd_idx,
    output logic [BLK_W-1:0]  blk,
    output logic [WORD_W-1:0] rd_word
);

    // Capture wins over shift; the controller never asserts both.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk <= '0;
        end else if (cap_en) begin
            blk <= cap_data;
        end else if (shift_en) begin
            blk <= {blk[BLK_W-WORD_W-1:0], shift_word};
        end
    end

    assign rd_word = word_at(blk, rd_idx);

endmodule

// File: rtl/seed_round_ctrl.sv
// Sequences the SEED round datapath: loads a 4-word block, runs ROUNDS two-phase
// rounds, captures the swapped halves and streams the ciphertext as 4 words.
module seed_round_ctrl
    import seed_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [HALF_W-1:0] blk_l,
    output logic [HALF_W-1:0] blk_r,
    output logic              dp_load,
    output logic              dp_start,
    output logic              dp_sync,
    output logic              dp_clk_en,
    output logic [RIDX_W-1:0] round_idx,
    input  logic [HALF_W-1:0] dp_l,
    input  logic [HALF_W-1:0] dp_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              busy
);

    localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(ROUNDS - 1);

    state_t              state, state_d;
    logic                phase, phase_d;
    logic [RIDX_W-1:0]   round_d;
    logic [WCNT_W-1:0]   in_cnt, in_cnt_d;
    logic [WCNT_W-1:0]   out_cnt, out_cnt_d;
    logic                in_ready_d, out_valid_d, busy_d;
    logic                dp_load_d, dp_start_d, dp_sync_d;
    logic                in_fire, out_fire, cap_en;
    logic [BLK_W-1:0]    blk;

    assign in_fire = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign cap_en  = (state == CAPTURE);

    // Next state, counters, and next values of the registered control outputs.
    always_comb begin
        state_d   = state;
        phase_d   = phase;
        round_d   = round_idx;
        in_cnt_d  = in_cnt;
        out_cnt_d = out_cnt;

        unique case (state)
            IDLE: begin
                if (in_fire) begin
                    in_cnt_d = in_cnt + 2'd1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (in_fire) begin
                    in_cnt_d = in_cnt + 2'd1;
                    if (in_cnt == 2'd3) begin
                        state_d = ROUND;
                        phase_d = 1'b0;
                        round_d = '0;
                    end
                end
            end
            ROUND: begin
                phase_d = ~phase;
                if (phase) begin
                    if (round_idx == LAST_ROUND) begin
                        state_d = CAPTURE;
                        round_d = '0;
                    end else begin
                        round_d = round_idx + RIDX_W'(1);
                    end
                end
            end
            CAPTURE: begin
                state_d   = OUT;
                out_cnt_d = '0;
            end
            OUT: begin
                if (out_fire) begin
                    out_cnt_d = out_cnt + 2'd1;
                    if (out_cnt == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
        dp_start_d  = (state_d == ROUND);
        dp_sync_d   = (state_d == ROUND) && phase_d;
        dp_load_d   = (state_d == ROUND) && !phase_d && (round_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 1'b0;
            round_idx <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            dp_start  <= 1'b0;
            dp_clk_en <= 1'b0;
            dp_sync   <= 1'b0;
            dp_load   <= 1'b0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            round_idx <= round_d;
            in_cnt    <= in_cnt_d;
            out_cnt   <= out_cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            dp_start  <= dp_start_d;
            dp_clk_en <= dp_start_d;
            dp_sync   <= dp_sync_d;
            dp_load   <= dp_load_d;
        end
    end

    // Final swap happens here: the result block is {R, L}.
    seed_word_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (in_fire),
        .shift_word (in_data),
        .cap_en     (cap_en),
        .cap_data   ({dp_r, dp_l}),
        .rd_idx     (out_cnt),
        .blk        (blk),
        .rd_word    (out_data)
    );

    assign blk_l = blk[BLK_W-1:HALF_W];
    assign blk_r = blk[HALF_W-1:0];

endmodule
